// File: rtl/row_scan_controller_if.sv
// Scan-control bundle between the frame/update logic and the row scan controller.
interface row_scan_controller_if;
  logic       run;
  logic       update_req;
  logic [2:0] row_addr;
  logic       row_ena;
  logic       frame_done;
  logic       update_ack;

  modport master (
    input  run, update_req,
    output row_addr, row_ena, frame_done, update_ack
  );

  modport slave (
    output run, update_req,
    input  row_addr, row_ena, frame_done, update_ack
  );
endinterface

// File: rtl/row_scan_controller.sv
// 8-row LED scan sequencer feeding decoder_3_to_8; all outputs registered, run=0 parks in IDLE next cycle.
// SCAN_BLANKING_EN defined: BLANK_CYCLES of row_ena=0 precede each row; undefined: rows drive back to back.
module row_scan_controller #(
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input logic                   clk,
  input logic                   rst,
  row_scan_controller_if.master scan_if
);

  localparam int unsigned MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
`ifdef SCAN_BLANKING_EN
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
`endif

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    row_addr_q;
  logic          row_ena_q;
  logic          frame_done_q;
  logic          update_ack_q;

  logic dwell_last;
  logic last_row;
  assign dwell_last = (cnt_q == DWELL_LAST);
  assign last_row   = (row_addr_q == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      row_addr_q   <= 3'd0;
      row_ena_q    <= 1'b0;
      frame_done_q <= 1'b0;
      update_ack_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      update_ack_q <= 1'b0;
      // Stopping abandons the partial frame: no boundary pulse, restart from row 0.
      if (state_q != S_IDLE && !scan_if.run) begin
        state_q    <= S_IDLE;
        cnt_q      <= '0;
        row_addr_q <= 3'd0;
        row_ena_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (scan_if.run) begin
              cnt_q <= '0;
`ifdef SCAN_BLANKING_EN
              state_q <= S_BLANK;
`else
              state_q   <= S_DRIVE;
              row_ena_q <= 1'b1;
`endif
            end
          end
`ifdef SCAN_BLANKING_EN
          S_BLANK: begin
            if (cnt_q == BLANK_LAST) begin
              cnt_q     <= '0;
              state_q   <= S_DRIVE;
              row_ena_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
`endif
          S_DRIVE: begin
            if (dwell_last) begin
              cnt_q        <= '0;
              row_addr_q   <= row_addr_q + 3'd1;
              frame_done_q <= last_row;
              update_ack_q <= last_row && scan_if.update_req;
`ifdef SCAN_BLANKING_EN
              // Row address moves together with row_ena dropping, so a lit row never changes.
              state_q   <= S_BLANK;
              row_ena_q <= 1'b0;
`endif
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            row_addr_q <= 3'd0;
            row_ena_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign scan_if.row_addr   = row_addr_q;
  assign scan_if.row_ena    = row_ena_q;
  assign scan_if.frame_done = frame_done_q;
  assign scan_if.update_ack = update_ack_q;

endmodule

// File: tb/tb_row_scan_controller.sv
// Bench for row_scan_controller: reference model derives outputs from elapsed cycles since scan start.
module tb_row_scan_controller;
  localparam int DWELL = 4;
`ifdef SCAN_BLANKING_EN
  localparam int BLANK = 2;
`else
  localparam int BLANK = 0;
`endif
  localparam int P     = DWELL + BLANK;
  localparam int FRAME = 8 * P;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  row_scan_controller_if scan_if ();

  row_scan_controller #(
    .DWELL_CYCLES(DWELL),
    .BLANK_CYCLES(2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .scan_if(scan_if)
  );

  int checks   = 0;
  int failures = 0;

  // Model state: act=scanning, k=cycles since the first state after leaving IDLE.
  bit       act = 1'b0;
  int       k   = 0;
  logic [5:0] exp_v;
  logic [5:0] obs;
  assign obs = {scan_if.row_addr, scan_if.row_ena, scan_if.frame_done, scan_if.update_ack};

  task automatic tick();
    logic req_s;
    logic fd;
    @(posedge clk);
    req_s = scan_if.update_req;
    if (rst) act = 1'b0;
    else if (!act) begin
      if (scan_if.run) begin act = 1'b1; k = 0; end
    end else if (!scan_if.run) act = 1'b0;
    else k++;
    if (!act) exp_v = 6'd0;
    else begin
      fd    = (k > 0) && (k % FRAME == 0);
      exp_v = {3'((k / P) % 8), 1'((k % P) >= BLANK), fd, fd && req_s};
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; scan_if.run = 1'b1; scan_if.update_req = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if (obs !== 6'd0) begin
        failures++; $display("FAIL reset_hold obs=%b exp=%b", obs, 6'd0);
      end
    end
    rst = 1'b0; scan_if.run = 1'b0; scan_if.update_req = 1'b0;
    repeat (2) begin
      tick();
      checks++;
      if (obs !== exp_v || obs !== 6'd0) begin
        failures++; $display("FAIL reset_idle obs=%b exp=%b", obs, 6'd0);
      end
    end
  endtask

  task automatic test_scan();
    int first_fd = -1;
    int fd_cnt   = 0;
    scan_if.run = 1'b1;
    for (int i = 0; i < 3 * FRAME + 4; i++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL scan cyc=%0d obs=%b exp=%b", i, obs, exp_v);
      end
      if (scan_if.frame_done === 1'b1) begin
        fd_cnt++;
        if (first_fd < 0) first_fd = i;
      end
      scan_if.update_req = 1'($urandom_range(0, 1));
    end
    scan_if.update_req = 1'b0;
    checks++;
    if (first_fd != FRAME) begin
      failures++; $display("FAIL first_frame_done got=%0d exp=%0d", first_fd, FRAME);
    end
    checks++;
    if (fd_cnt != 3) begin
      failures++; $display("FAIL frame_done_count got=%0d exp=3", fd_cnt);
    end
  endtask

  task automatic test_decoder();
    logic [7:0] dec, exp_dec, one;
    logic [2:0] prev_addr = 3'd0;
    logic       prev_ena  = 1'b0;
    one = 8'd1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      dec     = scan_if.row_ena ? (one << scan_if.row_addr) : 8'h00;
      exp_dec = exp_v[2] ? (one << exp_v[5:3]) : 8'h00;
      checks++;
      if (dec !== exp_dec || $countones(dec) > 1) begin
        failures++; $display("FAIL decoder cyc=%0d obs=%h exp=%h", i, dec, exp_dec);
      end
`ifdef SCAN_BLANKING_EN
      checks++;
      if (prev_ena && scan_if.row_ena && scan_if.row_addr !== prev_addr) begin
        failures++; $display("FAIL lit_row_glitch cyc=%0d obs=%0d exp=%0d", i, scan_if.row_addr, prev_addr);
      end
`endif
      prev_ena  = scan_if.row_ena;
      prev_addr = scan_if.row_addr;
    end
  endtask

  task automatic test_update();
    int  ack_cnt = 0;
    bit  found   = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL upd_wait obs=%b exp=%b", obs, exp_v);
      end
      if (act && exp_v[5:3] == 3'd3) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL upd_row3_timeout got=0 exp=1");
    end
    scan_if.update_req = 1'b1;
    for (int i = 0; i < FRAME + P; i++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL upd_grant cyc=%0d obs=%b exp=%b", i, obs, exp_v);
      end
      if (scan_if.update_ack === 1'b1) begin
        ack_cnt++;
        checks++;
        if (scan_if.frame_done !== 1'b1) begin
          failures++; $display("FAIL ack_with_frame_done obs=%b exp=1", scan_if.frame_done);
        end
        scan_if.update_req = 1'b0;
      end
    end
    checks++;
    if (ack_cnt != 1) begin
      failures++; $display("FAIL ack_count got=%0d exp=1", ack_cnt);
    end
    ack_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (scan_if.update_ack === 1'b1) ack_cnt++;
    end
    checks++;
    if (ack_cnt != 0) begin
      failures++; $display("FAIL ack_after_drop got=%0d exp=0", ack_cnt);
    end
  endtask

  task automatic test_stop();
    bit found     = 1'b0;
    int blank_cnt = 0;
    bit lit       = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      tick();
      if (act && exp_v[5:3] == 3'd5 && exp_v[2]) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL stop_row5_timeout got=0 exp=1");
    end
    scan_if.run = 1'b0;
    repeat (2) begin
      tick();
      checks++;
      if (obs !== 6'd0 || exp_v !== 6'd0) begin
        failures++; $display("FAIL stop_idle obs=%b exp=%b", obs, 6'd0);
      end
    end
    scan_if.run = 1'b1;
    for (int i = 0; i < 2 * P && !lit; i++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL restart cyc=%0d obs=%b exp=%b", i, obs, exp_v);
      end
      if (scan_if.row_ena === 1'b1) lit = 1'b1;
      else blank_cnt++;
    end
    checks++;
    if (!lit || blank_cnt != BLANK || scan_if.row_addr !== 3'd0) begin
      failures++; $display("FAIL restart_blank got=%0d/%0d exp=%0d/0", blank_cnt, scan_if.row_addr, BLANK);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      rst                = ($urandom_range(0, 299) == 0);
      scan_if.run        = ($urandom_range(0, 79) != 0);
      scan_if.update_req = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL random cyc=%0d obs=%b exp=%b", i, obs, exp_v);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_decoder();
    test_update();
    test_stop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
